// File: rtl/quadrature_encoder_tx.sv
// Quadrature encoder emulator: turns queued CW/CCW step requests into a Gray-coded A/B waveform.
// Optional QUAD_ERR_INJECT_EN adds i_inject, which forces one illegal (both-phase) excursion while idle.
module quadrature_encoder_tx #(
    parameter int DWELL_CYCLES   = 1000,
    parameter int EDGES_PER_STEP = 4,
    parameter int QUEUE_W        = 6
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               i_valid,
    input  logic               i_cw,
`ifdef QUAD_ERR_INJECT_EN
    input  logic               i_inject,
`endif
    output logic               o_ready,
    output logic               o_phase_a,
    output logic               o_phase_b,
    output logic               o_busy,
    output logic [QUEUE_W-1:0] o_pending
);

    localparam int TIMER_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int EDGE_W  = $clog2(EDGES_PER_STEP + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DWELL_CYCLES - 1);
    localparam logic [EDGE_W-1:0]  EDGE_LAST  = EDGE_W'(EDGES_PER_STEP - 1);
    localparam logic [QUEUE_W-1:0] MAX_POS    = QUEUE_W'((1 << (QUEUE_W - 1)) - 1);
    localparam logic [QUEUE_W-1:0] MAX_NEG    = QUEUE_W'(0) - MAX_POS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_INJ  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           phase_q, phase_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [EDGE_W-1:0]    edge_q, edge_d;
    logic                 dir_q, dir_d;
    logic [QUEUE_W-1:0]   pending_q, pending_d;
    logic                 accept, start;
    logic [QUEUE_W-1:0]   acc_delta, start_delta;

    // {A,B} Gray walk: CW 00->10->11->01, CCW is the reverse.
    function automatic logic [1:0] next_phase(input logic [1:0] ab, input logic cw);
        logic [1:0] nx;
        case (ab)
            2'b00:   nx = cw ? 2'b10 : 2'b01;
            2'b10:   nx = cw ? 2'b11 : 2'b00;
            2'b11:   nx = cw ? 2'b01 : 2'b10;
            default: nx = cw ? 2'b00 : 2'b11;
        endcase
        return nx;
    endfunction

    assign o_ready = !((i_cw && (pending_q == MAX_POS)) || (!i_cw && (pending_q == MAX_NEG)));
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        timer_d = timer_q;
        edge_d  = edge_q;
        dir_d   = dir_q;
        start   = 1'b0;
        case (state_q)
            S_IDLE: begin
`ifdef QUAD_ERR_INJECT_EN
                if (i_inject && (pending_q == '0)) begin
                    phase_d = ~phase_q;
                    timer_d = '0;
                    state_d = S_INJ;
                end else
`endif
                if (pending_q != '0) begin
                    start   = 1'b1;
                    dir_d   = ~pending_q[QUEUE_W-1];
                    timer_d = '0;
                    edge_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    phase_d = next_phase(phase_q, dir_q);
                    if (edge_q == EDGE_LAST) begin
                        edge_d = '0;
                        // Chain straight into the next queued step so spacing stays uniform.
                        if (pending_q != '0) begin
                            start = 1'b1;
                            dir_d = ~pending_q[QUEUE_W-1];
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        edge_d = edge_q + EDGE_W'(1);
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
`ifdef QUAD_ERR_INJECT_EN
            S_INJ: begin
                if (timer_q == TIMER_LAST) begin
                    phase_d = ~phase_q;
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_delta   = '0;
        start_delta = '0;
        if (accept) begin
            acc_delta = i_cw ? QUEUE_W'(1) : '1;
        end
        if (start) begin
            start_delta = pending_q[QUEUE_W-1] ? '1 : QUEUE_W'(1);
        end
        pending_d = pending_q + acc_delta - start_delta;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            phase_q   <= 2'b00;
            timer_q   <= '0;
            edge_q    <= '0;
            dir_q     <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            timer_q   <= timer_d;
            edge_q    <= edge_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
        end
    end

    assign o_phase_a = phase_q[1];
    assign o_phase_b = phase_q[0];
    assign o_busy    = (state_q != S_IDLE) || (pending_q != '0);
    assign o_pending = pending_q;

endmodule

// File: tb/tb_quadrature_encoder_tx.sv
// Directed bench for quadrature_encoder_tx: a 6-bit-queue instance for waveform checks and a
// 3-bit-queue instance for saturation checks, both with a 4-clock dwell and 4 edges per step.
module tb_quadrature_encoder_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid = 1'b0, cw = 1'b0, inject = 1'b0;
    logic ready, pa, pb, busy;
    logic [5:0] pend;
    logic v3 = 1'b0, cw3 = 1'b0;
    logic ready3, pa3, pb3, busy3;
    logic [2:0] pend3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    quadrature_encoder_tx #(.DWELL_CYCLES(4), .EDGES_PER_STEP(4), .QUEUE_W(6)) dut (
        .CLK(clk), .RST_N(rst_n), .i_valid(valid), .i_cw(cw),
`ifdef QUAD_ERR_INJECT_EN
        .i_inject(inject),
`endif
        .o_ready(ready), .o_phase_a(pa), .o_phase_b(pb), .o_busy(busy), .o_pending(pend)
    );

    quadrature_encoder_tx #(.DWELL_CYCLES(4), .EDGES_PER_STEP(4), .QUEUE_W(3)) dut3 (
        .CLK(clk), .RST_N(rst_n), .i_valid(v3), .i_cw(cw3),
`ifdef QUAD_ERR_INJECT_EN
        .i_inject(1'b0),
`endif
        .o_ready(ready3), .o_phase_a(pa3), .o_phase_b(pb3), .o_busy(busy3), .o_pending(pend3)
    );

    typedef struct {
        logic       v;
        logic       cw;
        int         n;
        logic [1:0] ab;
        logic       rdy;
        logic       busy;
        int         pend;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic c, input int n, input logic [1:0] ab,
                       input logic rdy, input logic b, input int p);
        vec_t r;
        r.v = v; r.cw = c; r.n = n; r.ab = ab; r.rdy = rdy; r.busy = b; r.pend = p;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int spend();
        return int'($signed(pend));
    endfunction

    function automatic int spend3();
        return int'($signed(pend3));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] cw_seq [4];
        logic [1:0] ab_prev;
        int cyc, last, trans, maxp;

        cw_seq[0] = 2'b00; cw_seq[1] = 2'b10; cw_seq[2] = 2'b11; cw_seq[3] = 2'b01;

        // Reset state, observed while reset is still asserted.
        #1;
        chk("rst_ab", {pa, pb}, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_pend", spend(), 0);
        chk("rst_ready", ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single CW step: first edge at k+5, then every 4 clocks, idle again at k+17.
        add(1, 1, 1, 2'b00, 1, 1, 1);
        add(0, 0, 1, 2'b00, 1, 1, 0);
        add(0, 0, 3, 2'b00, 1, 1, 0);
        add(0, 0, 1, 2'b10, 1, 1, 0);
        add(0, 0, 3, 2'b10, 1, 1, 0);
        add(0, 0, 1, 2'b11, 1, 1, 0);
        add(0, 0, 4, 2'b01, 1, 1, 0);
        add(0, 0, 3, 2'b01, 1, 1, 0);
        add(0, 0, 1, 2'b00, 1, 0, 0);
        // Single CCW step from 00.
        add(1, 0, 1, 2'b00, 1, 1, -1);
        add(0, 0, 1, 2'b00, 1, 1, 0);
        add(0, 0, 3, 2'b00, 1, 1, 0);
        add(0, 0, 1, 2'b01, 1, 1, 0);
        add(0, 0, 4, 2'b11, 1, 1, 0);
        add(0, 0, 4, 2'b10, 1, 1, 0);
        add(0, 0, 4, 2'b00, 1, 0, 0);
        // CW then a queued CCW: reversal chains with no extra gap (CCW edge at k+21).
        add(1, 1, 1, 2'b00, 1, 1, 1);
        add(0, 1, 1, 2'b00, 1, 1, 0);
        add(1, 0, 1, 2'b00, 1, 1, -1);
        add(0, 0, 3, 2'b10, 1, 1, -1);
        add(0, 0, 12, 2'b00, 1, 1, 0);
        add(0, 0, 4, 2'b01, 1, 1, 0);
        add(0, 0, 12, 2'b00, 1, 0, 0);
        // Opposite request cancels a queued step: only one step's waveform.
        add(1, 1, 1, 2'b00, 1, 1, 1);
        add(1, 1, 1, 2'b00, 1, 1, 1);
        add(1, 0, 1, 2'b00, 1, 1, 0);
        add(0, 0, 2, 2'b00, 1, 1, 0);
        add(0, 0, 1, 2'b10, 1, 1, 0);
        add(0, 0, 12, 2'b00, 1, 0, 0);

        foreach (tbl[i]) begin
            valid = tbl[i].v;
            cw    = tbl[i].cw;
            for (int j = 0; j < tbl[i].n; j++) tick();
            chk($sformatf("vec%0d_ab", i), {pa, pb}, tbl[i].ab);
            chk($sformatf("vec%0d_ready", i), ready, tbl[i].rdy);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("vec%0d_pend", i), spend(), tbl[i].pend);
            $display("vec %0d ab=%b%b busy=%b pend=%0d", i, pa, pb, busy, spend());
        end
        valid = 1'b0;

        // Five back-to-back CW requests: pending peaks at 4, 20 CW edges at 4-clock spacing.
        valid = 1'b1; cw = 1'b1;
        maxp = 0;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (spend() > maxp) maxp = spend();
        end
        valid = 1'b0;
        chk("burst_peak", maxp, 4);
        cyc = 4; last = 1; trans = 0; ab_prev = {pa, pb};
        while (busy && cyc < 200) begin
            tick();
            cyc++;
            if ({pa, pb} != ab_prev) begin
                chk("burst_seq", {pa, pb}, cw_seq[(trans + 1) % 4]);
                chk("burst_gap", cyc - last, 4);
                last = cyc; trans++; ab_prev = {pa, pb};
            end
        end
        chk("burst_edges", trans, 20);
        chk("burst_idle", busy, 0);
        chk("burst_pend", spend(), 0);
        $display("burst edges=%0d peak=%0d", trans, maxp);

        // Saturation on the 3-bit queue (MAX = 3).
        v3 = 1'b1; cw3 = 1'b1;
        repeat (4) tick();
        chk("sat_pend", spend3(), 3);
        chk("sat_ready_cw", ready3, 0);
        tick();
        chk("sat_hold", spend3(), 3);
        cw3 = 1'b0;
        #1;
        chk("sat_ready_ccw", ready3, 1);
        tick();
        chk("sat_ccw_pend", spend3(), 2);
        v3 = 1'b0;
        cyc = 0;
        while (busy3 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("sat_drain_busy", busy3, 0);
        chk("sat_drain_pend", spend3(), 0);
        $display("saturation drained after %0d cycles", cyc);

        // Async reset mid-step at 11 with one step still queued.
        valid = 1'b1; cw = 1'b1;
        repeat (2) tick();
        valid = 1'b0;
        repeat (8) tick();
        chk("mid_ab", {pa, pb}, 2'b11);
        chk("mid_pend", spend(), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ab", {pa, pb}, 2'b00);
        chk("arst_pend", spend(), 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        valid = 1'b1; cw = 1'b1;
        tick();
        valid = 1'b0;
        repeat (4) tick();
        chk("post_rst_wait", {pa, pb}, 2'b00);
        tick();
        chk("post_rst_first", {pa, pb}, 2'b10);
        $display("reset restart ab=%b%b", pa, pb);
        cyc = 0;
        while (busy && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("post_rst_idle", busy, 0);

`ifdef QUAD_ERR_INJECT_EN
        // Illegal excursion: both phases flip together, hold 4 clocks, flip back.
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk("inj_ab", {pa, pb}, 2'b11);
        chk("inj_busy", busy, 1);
        repeat (3) tick();
        chk("inj_hold", {pa, pb}, 2'b11);
        tick();
        chk("inj_restore", {pa, pb}, 2'b00);
        chk("inj_idle", busy, 0);
        chk("inj_pend", spend(), 0);
        $display("inject restore ab=%b%b", pa, pb);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
